full_ahead_nadder_acc: RTL
==========================

// Module: full_ahead_nadder_acc
// PURPOSE
//  Parametrised N-operand pipelined adder with optional running accumulation.
//  - Tree of 4:2 carry-save compressors, then one carry-propagate add; no ripple chain across operands.
//  - Valid pipeline tags every sample, so the block sits directly in streaming datapaths.
//  - Typical use: frequency/phase error summation in the RTMQ trap-frequency stabilisation loop.
// PARAMETERS
//  Width   32  operand and result width in bits (4..64).
//  NumOps  8   number of operands. Legal values: 4, 8, 16.
//  Stage   1   1 = register after every compressor level; 0 = compressor tree combinational.
// PORTS
//  i_clkp      in   1              clock, rising edge.
//  i_rstn      in   1              asynchronous reset, active low.
//  i_clr       in   1              synchronous flush: clears the pipeline and the accumulator.
//  i_vld       in   1              input sample valid.
//  i_acc       in   1              1 = add this sample to the running total; 0 = load a new total.
//  i_c         in   1              carry-in, added as LSB weight 1.
//  i_ops       in   NumOps*Width   packed operands, operand k = i_ops[k*Width +: Width], unsigned.
//  o_vld       out  1              result valid, 1-cycle pulse per input sample.
//  o_d         out  Width          result.
//  o_ovf       out  1              true result exceeded 2^Width-1 for this output.
// BEHAVIOUR
//  - Reset (i_rstn=0, asynchronous):
//    - all pipeline valids cleared;
//    - o_vld=0, o_d=0, o_ovf=0;
//    - accumulator=0.
//    - Samples in flight are discarded, not completed.
//  - Internal width: IW = Width + log2(NumOps) + 1. Operands are zero-extended; no loss inside the tree.
//  - Tree levels: L = log2(NumOps)-1 (4 ops -> 1, 8 -> 2, 16 -> 3).
//    - Each level pairs groups of 4 vectors into 2 via a 4:2 compressor.
//    - Carry vector is shifted left 1 with 0 fill.
//    - i_c enters as the carry-in of the first level.
//  - Stage R1: final CPA of sum + carry vectors, registered.
//  - Stage R2: accumulate/output register.
//  - Latency: L*Stage + 2 cycles from i_vld to o_vld, fixed. Full throughput: one sample per cycle, no stall.
//  - i_acc travels with its sample. At R2, with S = tree sum:
//    - acc=0: T = S;
//    - acc=1: T = acc_reg + S.
//    - o_ovf = (T >= 2^Width).
//  - Accumulator updates only on a valid sample reaching R2.
//    - o_d and acc_reg both take T[Width-1:0] (wrap build).
//    - o_d holds its value while o_vld=0.
//  - i_clr, synchronous, same cycle as i_vld:
//    - clr wins; that sample is dropped;
//    - all valids cleared; acc_reg=0;
//    - o_d/o_ovf hold their values; o_vld=0 the next cycle.
//  - Back-to-back acc=1 samples chain with no bubble. The R2 adder uses the value being written the same cycle (internal forward).
// CONFIGURATION
//  FAA_SAT_EN defined:
//    - on overflow, o_d = {Width{1'b1}} and acc_reg = {Width{1'b1}};
//    - accumulator stays saturated until an acc=0 sample, i_clr, or reset;
//    - o_ovf asserts for every output while saturated.
//  FAA_SAT_EN undefined: wrap-around modulo 2^Width as above. o_ovf still reported.
// TESTING (Width=32, NumOps=8, Stage=1 -> latency 4 unless noted)
//  1. Reset:
//     - ops all 1, acc=0, i_c=0 -> o_d=8, o_ovf=0, o_vld exactly 4 cycles later;
//     - assert i_rstn=0 mid-flight -> o_vld never pulses, o_d=0.
//  2. Accumulate: 5 back-to-back samples (op0=100, others 0, i_c=1), first acc=0 then acc=1 -> o_d = 101, 202, 303, 404, 505.
//  3. Overflow: 8 ops = 32'hFFFFFFFF, i_c=1, acc=0 -> T=0x7_FFFFFFF9:
//     - wrap build: o_d=32'hFFFFFFF9, o_ovf=1;
//     - FAA_SAT_EN build: o_d=32'hFFFFFFFF, o_ovf=1.
//  4. Saturation hold (FAA_SAT_EN): after test 3, sample ops=0 acc=1 -> o_d=32'hFFFFFFFF, o_ovf=1; next acc=0 ops=0 -> o_d=0, o_ovf=0.
//  5. Clear: i_clr with i_vld in cycle n, two samples in flight -> no o_vld for those; next acc=1 sample op0=7 -> o_d=7.
//  6. Random: 10k random samples, all NumOps in {4,8,16} x Stage in {0,1} -> match reference model; latency L*Stage+2 exact.

Source files
------------

// File: rtl/full_ahead_nadder_acc.sv
// N-operand pipelined adder: 4:2 carry-save tree, registered CPA, then accumulate/output stage.
// Build option: define FAA_SAT_EN for a saturating accumulator; the default build wraps modulo 2^Width.
module full_ahead_nadder_acc #(
    parameter int Width  = 32,
    parameter int NumOps = 8,
    parameter int Stage  = 1
) (
    input  logic                     i_clkp,
    input  logic                     i_rstn,
    input  logic                     i_clr,
    input  logic                     i_vld,
    input  logic                     i_acc,
    input  logic                     i_c,
    input  logic [NumOps*Width-1:0]  i_ops,
    output logic                     o_vld,
    output logic [Width-1:0]         o_d,
    output logic                     o_ovf
);

    localparam int LogN = $clog2(NumOps);
    localparam int IW   = Width + LogN + 1;
    localparam int Lvls = LogN - 1;
    localparam int VW   = NumOps * IW;

    // Two chained 3:2 stages give a 4:2 compression; cin fills the first carry LSB.
    function automatic logic [2*IW-1:0] comp42(input logic [IW-1:0] a, b, c, d,
                                               input logic cin);
        logic [IW-1:0] s1, c1, s2, c2;
        s1 = a ^ b ^ c;
        c1 = (((a & b) | (a & c) | (b & c)) << 1) | IW'(cin);
        s2 = s1 ^ c1 ^ d;
        c2 = ((s1 & c1) | (s1 & d) | (c1 & d)) << 1;
        return {c2, s2};
    endfunction

    logic [VW-1:0] lv_d   [0:Lvls];
    logic          lv_vld [0:Lvls];
    logic          lv_acc [0:Lvls];
    logic [VW-1:0] lv0;

    always_comb begin
        lv0 = '0;
        for (int k = 0; k < NumOps; k++) begin
            lv0[k*IW +: IW] = IW'(i_ops[k*Width +: Width]);
        end
    end

    // A flushed sample never enters the tree.
    assign lv_d[0]   = lv0;
    assign lv_vld[0] = i_vld & ~i_clr;
    assign lv_acc[0] = i_acc;

    for (genvar l = 0; l < Lvls; l++) begin : g_lvl
        localparam int NG = (NumOps >> l) / 4;
        logic [VW-1:0] cmb;
        logic [VW-1:0] q;
        logic          q_vld;
        logic          q_acc;
        logic          unused_hi;

        always_comb begin
            cmb = '0;
            for (int g = 0; g < NG; g++) begin
                {cmb[(2*g+1)*IW +: IW], cmb[2*g*IW +: IW]} =
                    comp42(lv_d[l][(4*g)*IW +: IW], lv_d[l][(4*g+1)*IW +: IW],
                           lv_d[l][(4*g+2)*IW +: IW], lv_d[l][(4*g+3)*IW +: IW],
                           (l == 0 && g == 0) ? i_c : 1'b0);
            end
        end

        if (Stage != 0) begin : g_reg
            always_ff @(posedge i_clkp or negedge i_rstn) begin
                if (!i_rstn) begin
                    q     <= '0;
                    q_vld <= 1'b0;
                    q_acc <= 1'b0;
                end else begin
                    q_vld <= lv_vld[l] & ~i_clr;
                    if (lv_vld[l]) begin
                        q     <= cmb;
                        q_acc <= lv_acc[l];
                    end
                end
            end
        end else begin : g_comb
            assign q     = cmb;
            assign q_vld = lv_vld[l];
            assign q_acc = lv_acc[l];
        end

        assign lv_d[l+1]   = q;
        assign lv_vld[l+1] = q_vld;
        assign lv_acc[l+1] = q_acc;
        // Slots beyond the vectors still alive at the next level carry zeros.
        assign unused_hi   = ^lv_d[l+1][VW-1:(NumOps >> (l+1))*IW];
    end

    logic [IW-1:0] r1_s;
    logic          r1_vld;
    logic          r1_acc;

    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            r1_s   <= '0;
            r1_vld <= 1'b0;
            r1_acc <= 1'b0;
        end else begin
            r1_vld <= lv_vld[Lvls] & ~i_clr;
            if (lv_vld[Lvls]) begin
                r1_s   <= lv_d[Lvls][IW-1:0] + lv_d[Lvls][2*IW-1:IW];
                r1_acc <= lv_acc[Lvls];
            end
        end
    end

    logic [Width-1:0] acc_q;
    logic [IW:0]      t_full;
    logic             t_ovf;
    logic [Width-1:0] t_d;
    logic             t_flag;

    assign t_full = (IW+1)'(r1_s) + (r1_acc ? (IW+1)'(acc_q) : '0);
    assign t_ovf  = |t_full[IW:Width];

`ifdef FAA_SAT_EN
    logic sat_q;
    logic sat_hit;

    // Once saturated, further accumulation keeps the pinned value until a load.
    assign sat_hit = t_ovf | (r1_acc & sat_q);
    assign t_d     = sat_hit ? {Width{1'b1}} : t_full[Width-1:0];
    assign t_flag  = sat_hit;

    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            sat_q <= 1'b0;
        end else if (i_clr) begin
            sat_q <= 1'b0;
        end else if (r1_vld) begin
            sat_q <= sat_hit;
        end
    end
`else
    assign t_d    = t_full[Width-1:0];
    assign t_flag = t_ovf;
`endif

    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            o_vld <= 1'b0;
            o_d   <= '0;
            o_ovf <= 1'b0;
            acc_q <= '0;
        end else if (i_clr) begin
            o_vld <= 1'b0;
            acc_q <= '0;
        end else begin
            o_vld <= r1_vld;
            if (r1_vld) begin
                o_d   <= t_d;
                o_ovf <= t_flag;
                acc_q <= t_d;
            end
        end
    end

endmodule
